comparador_serie_d_i: RTL and testbench

- Bit-serial, right-to-left (LSB-first) magnitude comparator.
- Sequential counterpart of the combinational comparator cell chain. It takes two WIDTH-bit words and an initial state bit, then walks the words one bit per clock from bit 0 to bit WIDTH-1, carrying the borrow state x between bits.
- The last step applies the final-cell function `p_x = ~((~a & x) | (b & x) | (~a & b))` to the MSB and registers the result.
- Sits between the operand registers and the flag consumer. Replaces a WIDTH-long cell chain when area matters more than latency.

---
 rtl/comparador_serie_d_i.sv | 178 +++++++++++++++++
 tb/tb_comparador_serie_d_i.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/comparador_serie_d_i.sv
// ---------------------------------------------------------------------------
// comparador_serie_d_i
//
// Bit-serial, LSB-first magnitude comparator. An accepted start captures two
// WIDTH-bit words and an initial borrow bit, then walks the words one bit per
// clock, carrying the borrow x of A - B - x from bit to bit. The MSB step
// evaluates the final cell and registers the result:
//   p_x = 1  iff  A >= B + x_in   (A, B unsigned)
//
// Timing for a start accepted in cycle T:
//   SHIFT in T+1 .. T+WIDTH, done/p_x valid in T+WIDTH+1, ready in T+WIDTH+2.
//
// Ports:
//   clk    : clock, rising edge
//   rst    : synchronous active-high reset (priority over start)
//   start  : request pulse, sampled only while ready = 1
//   a_in   : word A, captured on accepted start
//   b_in   : word B, captured on accepted start
//   x_in   : initial state (0 -> A >= B, 1 -> A > B)
//   ready  : high in IDLE
//   busy   : high in SHIFT
//   done   : one-cycle pulse when p_x becomes valid
//   p_x    : registered result, held until the next result is produced
//   eq     : (only with COMP_EQ_EN) registered A == B flag, held like p_x
//
// Optional feature macro: COMP_EQ_EN (adds the eq port and the sticky
// mismatch register d).
// ---------------------------------------------------------------------------
module comparador_serie_d_i #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             x_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             p_x
`ifdef COMP_EQ_EN
  ,
  output logic             eq
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  sa_q, sa_d;
  logic [WIDTH-1:0]  sb_q, sb_d;
  logic              x_q, x_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              p_x_q, p_x_d;

  // Current bit pair and the borrow it generates together with x_q.
  logic bit_a;
  logic bit_b;
  logic borrow;

  assign bit_a  = sa_q[0];
  assign bit_b  = sb_q[0];
  assign borrow = (~bit_a & x_q) | (bit_b & x_q) | (~bit_a & bit_b);

`ifdef COMP_EQ_EN
  logic d_q, d_d;
  logic eq_q, eq_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state and datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    p_x_d   = p_x_q;
`ifdef COMP_EQ_EN
    d_d     = d_q;
    eq_d    = eq_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a_in;
          sb_d    = b_in;
          x_d     = x_in;
          cnt_d   = '0;
`ifdef COMP_EQ_EN
          d_d     = 1'b0;
`endif
          state_d = SHIFT;
        end
      end

      SHIFT: begin
`ifdef COMP_EQ_EN
        // Sticky mismatch accumulates on every bit, the MSB included.
        d_d = d_q | (bit_a ^ bit_b);
`endif
        if (cnt_q == LAST_BIT) begin
          // MSB: the final cell inverts the borrow to give A >= B + x.
          p_x_d   = ~borrow;
`ifdef COMP_EQ_EN
          eq_d    = ~(d_q | (bit_a ^ bit_b));
`endif
          state_d = FIN;
        end else begin
          x_d   = borrow;
          sa_d  = sa_q >> 1;
          sb_d  = sb_q >> 1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      FIN: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      p_x_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
      p_x_q   <= p_x_d;
    end
  end

`ifdef COMP_EQ_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q  <= 1'b0;
      eq_q <= 1'b0;
    end else begin
      d_q  <= d_d;
      eq_q <= eq_d;
    end
  end

  assign eq = eq_q;
`endif

  // Status outputs decode directly from the registered state.
  assign ready = (state_q == IDLE);
  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == FIN);
  assign p_x   = p_x_q;

endmodule

// File: tb/tb_comparador_serie_d_i.sv
// ---------------------------------------------------------------------------
// tb_comparador_serie_d_i
//
// Self-checking bench for comparador_serie_d_i at WIDTH = 8. Expected results
// come from an arithmetic reference (A >= B + x, A == B). Covers a vector
// table, start-while-busy, reset mid-operation, back-to-back starts and a
// random sweep. Define COMP_EQ_EN to exercise the eq output as well.
// ---------------------------------------------------------------------------
module tb_comparador_serie_d_i;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         x_in;
  logic         ready;
  logic         busy;
  logic         done;
  logic         p_x;
`ifdef COMP_EQ_EN
  logic         eq;
`endif

  int checks   = 0;
  int failures = 0;

  comparador_serie_d_i #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .x_in  (x_in),
    .ready (ready),
    .busy  (busy),
    .done  (done),
    .p_x   (p_x)
`ifdef COMP_EQ_EN
    ,
    .eq    (eq)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: plain unsigned arithmetic.
  function automatic logic ref_px(input logic [W-1:0] a, input logic [W-1:0] b, input logic x);
    return (int'(a) >= int'(b) + int'(x));
  endfunction

  function automatic logic ref_eq(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a == b);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Runs one comparison starting at the next falling edge. Returns the
  // result, the eq flag (if present) and the start-to-done latency in cycles.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic x,
                       output logic got_px, output logic got_eq, output int lat);
    @(negedge clk);
    start = 1'b1;
    a_in  = a;
    b_in  = b;
    x_in  = x;
    @(negedge clk);
    start = 1'b0;
    a_in  = W'($urandom);
    b_in  = W'($urandom);
    x_in  = 1'($urandom);
    lat   = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got=no_done expected=done");
    end
    got_px = p_x;
`ifdef COMP_EQ_EN
    got_eq = eq;
`else
    got_eq = 1'b0;
`endif
  endtask

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         x;
    logic         exp_px;
    logic         exp_eq;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic px_r, eq_r, saw_done, exp_hold;
    int   lat;
    logic [W-1:0] ra, rb;
    logic rx;
    logic [W-1:0] b2b_a[36];
    logic [W-1:0] b2b_b[36];
    logic         b2b_x[36];

    vecs[0] = '{a: 8'h5A, b: 8'h5A, x: 1'b0, exp_px: 1'b1, exp_eq: 1'b1};
    vecs[1] = '{a: 8'h5A, b: 8'h5A, x: 1'b1, exp_px: 1'b0, exp_eq: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'hFF, x: 1'b0, exp_px: 1'b0, exp_eq: 1'b0};
    vecs[3] = '{a: 8'hFF, b: 8'h00, x: 1'b1, exp_px: 1'b1, exp_eq: 1'b0};
    vecs[4] = '{a: 8'h00, b: 8'h00, x: 1'b1, exp_px: 1'b0, exp_eq: 1'b1};
    vecs[5] = '{a: 8'h01, b: 8'h00, x: 1'b1, exp_px: 1'b1, exp_eq: 1'b0};
    vecs[6] = '{a: 8'h80, b: 8'h7F, x: 1'b0, exp_px: 1'b1, exp_eq: 1'b0};

    rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; x_in = 1'b0;
    repeat (3) @(negedge clk);
    // Start during reset must be ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst   = 1'b0;
    check("reset_ready", ready, 1);
    check("reset_busy",  busy,  0);
    check("reset_done",  done,  0);
    check("reset_px",    p_x,   0);
`ifdef COMP_EQ_EN
    check("reset_eq",    eq,    0);
`endif

    // ---------------- vector table ----------------
    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].x, px_r, eq_r, lat);
      $display("vec %0d: A=%02h B=%02h x=%0d -> p_x=%0d lat=%0d", i, vecs[i].a, vecs[i].b, vecs[i].x, px_r, lat);
      check($sformatf("vec%0d_latency", i), lat, W + 1);
      check($sformatf("vec%0d_px", i), px_r, vecs[i].exp_px);
`ifdef COMP_EQ_EN
      check($sformatf("vec%0d_eq", i), eq_r, vecs[i].exp_eq);
`endif
    end

    // ---------------- start while busy ----------------
    // Previous result is 1 (0x80 vs 0x7F), so p_x=0 proves a fresh result.
    @(negedge clk);
    check("busy_pre_ready", ready, 1);
    start = 1'b1; a_in = 8'h10; b_in = 8'h20; x_in = 1'b0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (c <= W + 1) check($sformatf("busy_ready_c%0d", c), ready, 0);
      if (c == W + 1) begin
        check("busy_done", done, 1);
        check("busy_px", p_x, 0);
      end
      if (c == W + 2) check("busy_back_ready", ready, 1);
      if (c == 3) begin
        start = 1'b1; a_in = 8'hFF; b_in = 8'h00;
      end else begin
        start = 1'b0;
      end
    end
    $display("start_while_busy: p_x=%0d", p_x);

    // ---------------- reset mid-operation ----------------
    do_op(8'h03, 8'h02, 1'b0, px_r, eq_r, lat);
    check("prerst_px", px_r, 1);
    @(negedge clk);
    start = 1'b1; a_in = 8'h10; b_in = 8'h01; x_in = 1'b0;
    saw_done = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) saw_done = 1'b1;
      if (c == 4) rst = 1'b1;
      if (c == 5) begin
        rst = 1'b0;
        check("midrst_ready", ready, 1);
        check("midrst_busy",  busy,  0);
        check("midrst_px",    p_x,   0);
      end
    end
    check("midrst_no_done", saw_done, 0);
    do_op(8'h03, 8'h02, 1'b0, px_r, eq_r, lat);
    $display("after_reset: A=03 B=02 x=0 -> p_x=%0d", px_r);
    check("postrst_px", px_r, 1);

    // ---------------- back-to-back ----------------
    for (int c = 0; c < 36; c++) begin
      b2b_a[c] = W'($urandom);
      b2b_b[c] = W'($urandom);
      b2b_x[c] = 1'($urandom);
    end
    @(negedge clk);
    start = 1'b1; a_in = b2b_a[0]; b_in = b2b_b[0]; x_in = b2b_x[0];
    exp_hold = 1'b0;
    for (int c = 1; c < 36; c++) begin
      @(negedge clk);
      check($sformatf("b2b_done_c%0d", c), done, (c == 9 || c == 19 || c == 29));
      if (c == 9 || c == 19 || c == 29) begin
        exp_hold = ref_px(b2b_a[c-9], b2b_b[c-9], b2b_x[c-9]);
        $display("b2b op at c=%0d: A=%02h B=%02h x=%0d -> p_x=%0d", c - 9,
                 b2b_a[c-9], b2b_b[c-9], b2b_x[c-9], p_x);
      end
      if (c >= 9) check($sformatf("b2b_px_c%0d", c), p_x, exp_hold);
      start = (c <= 25);
      a_in  = b2b_a[c];
      b_in  = b2b_b[c];
      x_in  = b2b_x[c];
    end
    start = 1'b0;

    // ---------------- random sweep ----------------
    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = (n % 4 == 0) ? ra : W'($urandom);
      rx = 1'($urandom);
      do_op(ra, rb, rx, px_r, eq_r, lat);
      $display("rnd %0d: A=%02h B=%02h x=%0d -> p_x=%0d", n, ra, rb, rx, px_r);
      check("rnd_px", px_r, ref_px(ra, rb, rx));
`ifdef COMP_EQ_EN
      check("rnd_eq", eq_r, ref_eq(ra, rb));
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
